// File: rtl/bist_misr_ctrl.sv
// Response compactor for LFSR-driven BIST: folds each CUT response into a 9-bit MISR
// (x^9 + x^4 + 1), counts patterns and reports a sticky done/pass verdict.
module bist_misr_ctrl #(
    parameter int unsigned NUM_PATTERNS = 511,
    parameter logic [8:0]  GOLDEN       = 9'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       resp_valid,
    input  logic [8:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] signature,
    output logic [9:0] pattern_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] LAST_CNT = 10'(NUM_PATTERNS);

    state_t     state_q, state_d;
    logic [8:0] sig_q, sig_d;
    logic [9:0] cnt_q, cnt_d;
    logic       accept;
    logic [8:0] misr_next;

    // Handshake: resp_valid alone qualifies resp; there is no ready. A response is
    // consumed on any edge where state is RUN and resp_valid is high, otherwise dropped.
    assign accept = (state_q == RUN) && resp_valid;

    // Tap at bit 3 feeds bit 0 together with the overflow bit 8.
    assign misr_next = {sig_q[7:0], sig_q[8] ^ sig_q[3]} ^ resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sig_q   <= 9'h000;
            cnt_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    sig_d   = 9'h000;
                    cnt_d   = 10'd0;
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q + 10'd1 == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = 9'h000;
                cnt_d   = 10'd0;
            end
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pass        = done && (sig_q == GOLDEN);
    assign signature   = sig_q;
    assign pattern_cnt = cnt_q;

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// Directed bench for bist_misr_ctrl: four instances with different run lengths and
// golden values, each stepped through hand-computed MISR sequences.
module tb_bist_misr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] start;
    logic [3:0] rv;
    logic [8:0] resp [4];
    logic [3:0] busy, done, pass;
    logic [8:0] sig [4];
    logic [9:0] cnt [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: default (511, 000)  1: single (1, 001)  2: feedback (2, 002)  3: gapped (2, 000)
    bist_misr_ctrl #(.NUM_PATTERNS(511), .GOLDEN(9'h000)) u_def (
        .clk(clk), .reset(reset), .start(start[0]), .resp_valid(rv[0]), .resp(resp[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]), .pattern_cnt(cnt[0]));
    bist_misr_ctrl #(.NUM_PATTERNS(1), .GOLDEN(9'h001)) u_one (
        .clk(clk), .reset(reset), .start(start[1]), .resp_valid(rv[1]), .resp(resp[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]), .pattern_cnt(cnt[1]));
    bist_misr_ctrl #(.NUM_PATTERNS(2), .GOLDEN(9'h002)) u_two (
        .clk(clk), .reset(reset), .start(start[2]), .resp_valid(rv[2]), .resp(resp[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]), .pattern_cnt(cnt[2]));
    bist_misr_ctrl #(.NUM_PATTERNS(2), .GOLDEN(9'h000)) u_gap (
        .clk(clk), .reset(reset), .start(start[3]), .resp_valid(rv[3]), .resp(resp[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]), .pattern_cnt(cnt[3]));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int idx);
        start[idx] = 1'b1;
        step();
        start[idx] = 1'b0;
    endtask

    task automatic accept(input int idx, input logic [8:0] r);
        resp[idx] = r;
        rv[idx]   = 1'b1;
        step();
        rv[idx]   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = '0;
        rv    = '0;
        for (int i = 0; i < 4; i++) resp[i] = 9'h000;
        step();
        step();
        reset = 1'b0;

        check("rst_busy", 16'(busy[0]), 16'd0);
        check("rst_done", 16'(done[0]), 16'd0);
        check("rst_pass", 16'(pass[0]), 16'd0);
        check("rst_sig",  16'(sig[0]),  16'h000);
        check("rst_cnt",  16'(cnt[0]),  16'd0);

        // reset and start together: reset wins
        reset = 1'b1;
        start[0] = 1'b1;
        step();
        reset = 1'b0;
        start[0] = 1'b0;
        check("rst_start_busy", 16'(busy[0]), 16'd0);

        // reset mid-run
        do_start(0);
        check("start_busy", 16'(busy[0]), 16'd1);
        check("start_cnt",  16'(cnt[0]),  16'd0);
        for (int i = 0; i < 5; i++) accept(0, 9'h0AA);
        check("mid_cnt", 16'(cnt[0]), 16'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", 16'(busy[0]), 16'd0);
        check("midrst_done", 16'(done[0]), 16'd0);
        check("midrst_sig",  16'(sig[0]),  16'h000);
        check("midrst_cnt",  16'(cnt[0]),  16'd0);

        // full period of all-zero responses
        do_start(0);
        check("rerun_busy", 16'(busy[0]), 16'd1);
        check("rerun_cnt",  16'(cnt[0]),  16'd0);
        resp[0] = 9'h000;
        rv[0] = 1'b1;
        for (int i = 0; i < 100; i++) step();
        rv[0] = 1'b0;
        check("full_cnt100", 16'(cnt[0]), 16'd100);
        do_start(0);
        check("run_start_cnt",  16'(cnt[0]),  16'd100);
        check("run_start_busy", 16'(busy[0]), 16'd1);
        rv[0] = 1'b1;
        for (int i = 0; i < 410; i++) step();
        rv[0] = 1'b0;
        check("full_cnt510",  16'(cnt[0]),  16'd510);
        check("full_done510", 16'(done[0]), 16'd0);
        accept(0, 9'h000);
        check("full_done", 16'(done[0]), 16'd1);
        check("full_busy", 16'(busy[0]), 16'd0);
        check("full_cnt",  16'(cnt[0]),  16'd511);
        check("full_sig",  16'(sig[0]),  16'h000);
        check("full_pass", 16'(pass[0]), 16'd1);
        accept(0, 9'h155);
        check("full_freeze_sig", 16'(sig[0]), 16'h000);
        do_start(0);
        check("done_start_busy", 16'(busy[0]), 16'd1);
        check("done_start_done", 16'(done[0]), 16'd0);
        check("done_start_cnt",  16'(cnt[0]),  16'd0);

        // single pattern
        do_start(1);
        accept(1, 9'h001);
        check("one_done", 16'(done[1]), 16'd1);
        check("one_sig",  16'(sig[1]),  16'h001);
        check("one_cnt",  16'(cnt[1]),  16'd1);
        check("one_pass", 16'(pass[1]), 16'd1);
        accept(1, 9'h1FF);
        check("one_hold_sig", 16'(sig[1]), 16'h001);
        check("one_hold_cnt", 16'(cnt[1]), 16'd1);
        // start with resp_valid in DONE: response not compacted
        start[1] = 1'b1;
        rv[1] = 1'b1;
        resp[1] = 9'h1FF;
        step();
        start[1] = 1'b0;
        rv[1] = 1'b0;
        check("one_sv_busy", 16'(busy[1]), 16'd1);
        check("one_sv_sig",  16'(sig[1]),  16'h000);
        check("one_sv_cnt",  16'(cnt[1]),  16'd0);

        // feedback path, failing compare
        do_start(2);
        accept(2, 9'h1FF);
        check("fb_sig1",  16'(sig[2]),  16'h1FF);
        check("fb_done1", 16'(done[2]), 16'd0);
        accept(2, 9'h1FF);
        check("fb_sig2", 16'(sig[2]),  16'h001);
        check("fb_done", 16'(done[2]), 16'd1);
        check("fb_pass", 16'(pass[2]), 16'd0);

        // gapped stream
        do_start(3);
        accept(3, 9'h001);
        check("gap_sig1", 16'(sig[3]), 16'h001);
        for (int i = 0; i < 3; i++) begin
            step();
            check("gap_idle_done", 16'(done[3]), 16'd0);
        end
        check("gap_idle_cnt", 16'(cnt[3]), 16'd1);
        accept(3, 9'h000);
        check("gap_sig",  16'(sig[3]),  16'h002);
        check("gap_cnt",  16'(cnt[3]),  16'd2);
        check("gap_done", 16'(done[3]), 16'd1);
        check("gap_pass", 16'(pass[3]), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_misr_ctrl.md
# bist_misr_ctrl

Response-side BIST stage that sits directly downstream of the 9-bit random-pattern LFSR (x^9 + x^4 + 1). It compacts the circuit-under-test response to each LFSR pattern into a 9-bit multiple-input signature register (MISR) that uses the same polynomial. It also counts the accepted patterns. After a programmed number of patterns it stops and compares the final signature against a golden value, producing a sticky done/pass result for the test controller.

## Interface
- `NUM_PATTERNS`, default 511: responses to compact per run. Legal range is 1..511, one full LFSR period maximum.
- `GOLDEN`, default 9'h000: expected final signature. Set per CUT from the golden-model run.
- `clk`  in  1  : single clock. All state changes on the rising edge.
- `reset`  in  1  : synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `start`  in  1  : begin a run. Honoured in IDLE or DONE only.
- `resp_valid`  in  1  : `resp` holds a valid CUT response this cycle.
- `resp`  in  9  : CUT response to the current LFSR pattern.
- `busy`  out  1  : high in RUN.
- `done`  out  1  : high in DONE. Level, held until `start` or `reset`.
- `pass`  out  1  : `done && (signature == GOLDEN)`. Combinational from registers.
- `signature`  out  9  : current MISR contents.
- `pattern_cnt`  out  10  : number of responses accepted in the current run.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE -> RUN on `start`. On that edge: `signature` <= 0 and `pattern_cnt` <= 0.
- DONE -> RUN on `start`, with the same clearing as from IDLE.
- `start` while in RUN is ignored. The run is not restarted.
- Accept condition: state == RUN && `resp_valid`. In any other state `resp`/`resp_valid` are ignored and `signature` holds.
- MISR update on accept (s = current signature, r = `resp`):
  - next[0] = s[8] ^ s[3] ^ r[0]
  - next[i] = s[i-1] ^ r[i] for i = 1..8
- `pattern_cnt` increments by 1 on each accept. No wrap is reachable because `NUM_PATTERNS` ≤ 511 fits in 10 bits.
- RUN -> DONE on the accept that makes `pattern_cnt` reach `NUM_PATTERNS`. That final response is included in the signature.
- Freeze in DONE: `signature` and `pattern_cnt` hold their final values until the next `start` or `reset`.
- Gaps: `resp_valid` low in RUN leaves all state unchanged. Gaps of any length are allowed.
- `reset` has priority over every other input. When asserted at any point, including mid-run, it forces the following on the next edge:
  - state = IDLE
  - `signature` = 0
  - `pattern_cnt` = 0
  - the partial run is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `signature`=9'h000, `pattern_cnt`=0.
- Start latency: `start` sampled at edge t gives `busy`=1 after edge t. The first response can be accepted at edge t+1.
- Throughput: one response per clock while `resp_valid` is held high. `NUM_PATTERNS` back-to-back accepts finish the run in `NUM_PATTERNS` cycles.
- Completion: after the final accepting edge, `done`=1, `busy`=0 and `pass` is valid, all in the same cycle. There is no extra compare cycle.
- `start` and `resp_valid` asserted together in IDLE or DONE: only the start takes effect, and that cycle's `resp` is not compacted.
- `start` and `reset` asserted together: reset wins and the state is IDLE.

## Test plan
- Reset mid-run:
  - Stimulus: default parameters; start, then 5 accepts of 9'h0AA; then `reset` for 1 cycle.
  - Required: next cycle `busy`=0, `done`=0, `signature`=000, `pattern_cnt`=0; a subsequent `start` behaves as from IDLE.
- Single pattern:
  - Stimulus: `NUM_PATTERNS`=1, `GOLDEN`=9'h001; start, then one accept of `resp`=9'h001.
  - Required: next cycle `done`=1, `signature`=001, `pattern_cnt`=1, `pass`=1; further `resp_valid` pulses leave `signature` unchanged.
- Feedback path and failing compare:
  - Stimulus: `NUM_PATTERNS`=2, `GOLDEN`=9'h002; accepts of 9'h1FF then 9'h1FF.
  - Required: `signature`=1FF after the first accept and 001 after the second; `done`=1, `pass`=0.
- Gapped stream:
  - Stimulus: `NUM_PATTERNS`=2; accepts of 9'h001, then 3 idle cycles, then 9'h000.
  - Required: `signature`=002, `pattern_cnt`=2, `done` rises only after the second accept.
- Full period:
  - Stimulus: `NUM_PATTERNS`=511, `GOLDEN`=9'h000; all-zero responses.
  - Required: `done` after exactly 511 accepts, `signature`=000, `pass`=1; `start` during RUN ignored (count unaffected); `start` in DONE clears and reruns.
